// File: rtl/registro_tablero_if.sv
// rtl/registro_tablero_if.sv - write/clear/read bus of the board-cell register bank
//   master: drives escribir, direccion, dato, borrar, leer_dir
//   slave : returns salida_dato, ocupado, cuenta, lleno, rechazo, listo
interface registro_tablero_if #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 9,
  parameter int AW    = 4
);
  logic             escribir;
  logic [AW-1:0]    direccion;
  logic [WIDTH-1:0] dato;
  logic             borrar;
  logic [AW-1:0]    leer_dir;
  logic [WIDTH-1:0] salida_dato;
  logic [DEPTH-1:0] ocupado;
  logic [AW-1:0]    cuenta;
  logic             lleno;
  logic             rechazo;
  logic             listo;

  modport master (
    output escribir, direccion, dato, borrar, leer_dir,
    input  salida_dato, ocupado, cuenta, lleno, rechazo, listo
  );

  modport slave (
    input  escribir, direccion, dato, borrar, leer_dir,
    output salida_dato, ocupado, cuenta, lleno, rechazo, listo
  );
endinterface

// File: rtl/registro_tablero.sv
// rtl/registro_tablero.sv - write-once board-cell register bank with sequential clear sweep
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : registro_tablero_if.slave (write port, clear request, read port, status flags)
module registro_tablero #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 9,
  parameter int AW    = 4
) (
  input logic               clk,
  input logic               reset,
  registro_tablero_if.slave bus
);

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
  localparam logic [AW-1:0] ULTIMO  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] UNO     = AW'(1);

  typedef enum logic {INACTIVO, BORRANDO} estado_t;

  estado_t          estado, estado_sig;
  logic [AW-1:0]    indice;
  logic [WIDTH-1:0] celdas [DEPTH];
  logic [WIDTH-1:0] salida_dato;
  logic [DEPTH-1:0] ocupado;
  logic [AW-1:0]    cuenta;
  logic             lleno;
  logic             rechazo;
  logic             dir_valida;
  logic             lee_valida;
  logic             acepta;
  logic             fin_barrido;

  assign dir_valida  = (bus.direccion < DEPTH_A);
  assign lee_valida  = (bus.leer_dir < DEPTH_A);
  // borrar has priority over a same-cycle write, so it disqualifies acceptance
  assign acepta      = (estado == INACTIVO) && bus.escribir && !bus.borrar &&
                       dir_valida && !ocupado[bus.direccion];
  assign fin_barrido = (estado == BORRANDO) && (indice == ULTIMO);

  assign bus.salida_dato = salida_dato;
  assign bus.ocupado     = ocupado;
  assign bus.cuenta      = cuenta;
  assign bus.lleno       = lleno;
  assign bus.rechazo     = rechazo;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) estado <= INACTIVO;
    else       estado <= estado_sig;
  end

  // next-state logic; borrar during BORRANDO is ignored
  always_comb begin
    estado_sig = estado;
    case (estado)
      INACTIVO: if (bus.borrar) estado_sig = BORRANDO;
      BORRANDO: if (fin_barrido) estado_sig = INACTIVO;
      default:  estado_sig = INACTIVO;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    bus.listo = 1'b0;
    if (estado == INACTIVO) bus.listo = 1'b1;
  end

  // cell storage, flags, counters and read path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) celdas[i] <= '0;
      ocupado     <= '0;
      cuenta      <= '0;
      lleno       <= 1'b0;
      rechazo     <= 1'b0;
      salida_dato <= '0;
      indice      <= '0;
    end else begin
      // read samples the pre-edge contents, giving read-before-write
      salida_dato <= lee_valida ? celdas[bus.leer_dir] : '0;
      rechazo     <= bus.escribir && !acepta;
      case (estado)
        INACTIVO: begin
          if (bus.borrar) begin
            indice <= '0;
          end else if (acepta) begin
            celdas[bus.direccion]  <= bus.dato;
            ocupado[bus.direccion] <= 1'b1;
            cuenta                 <= cuenta + UNO;
            lleno                  <= ((cuenta + UNO) == DEPTH_A);
          end
        end
        BORRANDO: begin
          celdas[indice]  <= '0;
          ocupado[indice] <= 1'b0;
          indice          <= indice + UNO;
          // cuenta and lleno hold their values until the whole sweep is done
          if (fin_barrido) begin
            cuenta <= '0;
            lleno  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_registro_tablero.sv
// tb/tb_registro_tablero.sv - self-checking bench for registro_tablero
module tb_registro_tablero;

  logic clk;
  logic reset;

  registro_tablero_if #(.WIDTH(6), .DEPTH(9), .AW(4)) bus ();

  registro_tablero #(.WIDTH(6), .DEPTH(9), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [5:0] m_cell [9];
  logic [8:0] m_occ;
  int         m_cnt;
  bit         m_busy;
  int         m_idx;
  logic [5:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) m_cell[i] = '0;
    m_occ  = '0;
    m_cnt  = 0;
    m_busy = 1'b0;
    m_idx  = 0;
    sb.delete();
  endtask

  task automatic check_flags(input logic rej);
    check("rechazo", 32'(bus.rechazo), 32'(rej));
    check("cuenta",  32'(bus.cuenta),  32'(m_cnt));
    check("ocupado", 32'(bus.ocupado), 32'(m_occ));
    check("lleno",   32'(bus.lleno),   32'(m_cnt == 9));
    check("listo",   32'(bus.listo),   32'(!m_busy));
  endtask

  // one clock cycle: drive at negedge, predict, compare #1 after the rising edge
  task automatic cyc(input logic esc, input logic [3:0] dir, input logic [5:0] dat,
                     input logic bor, input logic [3:0] rd);
    logic acc;
    logic rej;
    logic [5:0] exp_rd;
    @(negedge clk);
    bus.escribir  = esc;
    bus.direccion = dir;
    bus.dato      = dat;
    bus.borrar    = bor;
    bus.leer_dir  = rd;
    acc = 1'b0;
    if (!m_busy && esc && !bor && dir < 9) acc = !m_occ[dir];
    rej = esc && !acc;
    exp_rd = (rd < 9) ? m_cell[rd] : 6'h00;
    sb.push_back(exp_rd);
    @(posedge clk);
    if (m_busy) begin
      m_cell[m_idx] = '0;
      m_occ[m_idx]  = 1'b0;
      if (m_idx == 8) begin
        m_busy = 1'b0;
        m_cnt  = 0;
      end
      m_idx++;
    end else if (bor) begin
      m_busy = 1'b1;
      m_idx  = 0;
    end else if (acc) begin
      m_cell[dir] = dat;
      m_occ[dir]  = 1'b1;
      m_cnt++;
    end
    #1;
    check("salida_dato", 32'(bus.salida_dato), 32'(sb.pop_front()));
    check_flags(rej);
  endtask

  task automatic idle(input logic [3:0] rd);
    cyc(1'b0, 4'd0, 6'h00, 1'b0, rd);
  endtask

  initial begin
    int bajo;
    bus.escribir  = 1'b0;
    bus.direccion = '0;
    bus.dato      = '0;
    bus.borrar    = 1'b0;
    bus.leer_dir  = '0;
    reset = 1'b1;
    model_reset();
    #1;
    check("reset_salida", 32'(bus.salida_dato), 32'h0);
    check_flags(1'b0);
    @(negedge clk);
    reset = 1'b0;

    // single write then read back
    cyc(1'b1, 4'd4, 6'h15, 1'b0, 4'd4);
    idle(4'd4);
    check("plan_ocupado", 32'(bus.ocupado), 32'h010);
    check("plan_leer4", 32'(bus.salida_dato), 32'h15);

    // overwrite of an occupied cell
    cyc(1'b1, 4'd4, 6'h2A, 1'b0, 4'd4);
    idle(4'd4);
    idle(4'd4);
    check("plan_no_sobrescribe", 32'(bus.salida_dato), 32'h15);

    // fill the board, then a tenth write
    for (int i = 0; i < 9; i++) cyc(1'b1, 4'(i), 6'(6'h20 + i), 1'b0, 4'(i));
    check("plan_lleno", 32'(bus.lleno), 32'h1);
    check("plan_cuenta9", 32'(bus.cuenta), 32'd9);
    cyc(1'b1, 4'd0, 6'h3F, 1'b0, 4'd0);
    for (int i = 0; i < 9; i++) idle(4'(i));

    // clear sweep with a write attempt in the middle
    bajo = 0;
    cyc(1'b0, 4'd0, 6'h00, 1'b1, 4'd0);
    if (bus.listo == 1'b0) bajo++;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) cyc(1'b1, 4'd3, 6'h07, 1'b1, 4'(i));
      else        idle(4'(i));
      if (bus.listo == 1'b0) bajo++;
    end
    check("listo_bajo_ciclos", 32'(bajo), 32'd9);
    for (int i = 0; i < 9; i++) idle(4'(i));

    // borrar and escribir together, then out-of-range write
    cyc(1'b1, 4'd5, 6'h11, 1'b0, 4'd5);
    cyc(1'b1, 4'd2, 6'h01, 1'b1, 4'd2);
    for (int i = 0; i < 9; i++) idle(4'd2);
    check("plan_celda2", 32'(bus.salida_dato), 32'h0);
    cyc(1'b1, 4'd12, 6'h3F, 1'b0, 4'd12);
    idle(4'd12);
    idle(4'd5);

    // async reset during the sweep with cells 5..8 still loaded
    for (int i = 5; i < 9; i++) cyc(1'b1, 4'(i), 6'(6'h30 + i), 1'b0, 4'(i));
    cyc(1'b0, 4'd0, 6'h00, 1'b1, 4'd6);
    for (int i = 0; i < 3; i++) idle(4'd6);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_salida", 32'(bus.salida_dato), 32'h0);
    check_flags(1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) idle(4'(i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
